rob_gen2: RTL and testbench

- Parametrised second-generation reorder buffer: in-order allocation from decode, out-of-order result write-back from NUM_WB execution/memory ports, in-order single-entry commit to register file, memory and branch predictor.
- Uses all DEPTH slots, via an explicit occupancy counter.
- Detects branch/JALR mispredictions at commit and raises a one-cycle flush.
- Provides two operand-lookup ports for decode.

---
 rtl/rob_gen2.sv | 220 ++++++++++++++++++++++
 tb/tb_rob_gen2.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_gen2.sv
// rob_gen2: reorder buffer with in-order alloc/commit, out-of-order write-back; commit issues 1 cycle after head is done, stores wait on store_ready_in.
// Optional macro ROB_WB_BYPASS_EN: operand queries also see same-cycle write-back and done-at-allocate results.
module rob_gen2 #(
  parameter int DEPTH_W = 5,
  parameter int NUM_WB  = 3,
  parameter int REG_W   = 5
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      rdy_in,
  input  logic                      alloc_valid_in,
  output logic                      alloc_ready_out,
  input  logic [2:0]                alloc_type_in,
  input  logic [REG_W-1:0]          alloc_dest_in,
  input  logic [31:0]               alloc_pc_in,
  input  logic                      alloc_pred_taken_in,
  input  logic [31:0]               alloc_pred_addr_in,
  input  logic                      alloc_done_in,
  input  logic [31:0]               alloc_value_in,
  output logic [DEPTH_W-1:0]        alloc_id_out,
  input  logic [NUM_WB-1:0]         wb_valid_in,
  input  logic [NUM_WB*DEPTH_W-1:0] wb_id_in,
  input  logic [NUM_WB*32-1:0]      wb_value_in,
  input  logic [NUM_WB*32-1:0]      wb_addr_in,
  input  logic [DEPTH_W-1:0]        query_id1_in,
  input  logic [DEPTH_W-1:0]        query_id2_in,
  output logic                      query_hit1_out,
  output logic                      query_hit2_out,
  output logic [31:0]               query_val1_out,
  output logic [31:0]               query_val2_out,
  input  logic                      store_ready_in,
  output logic                      commit_valid_out,
  output logic [2:0]                commit_type_out,
  output logic [REG_W-1:0]          commit_dest_out,
  output logic [31:0]               commit_value_out,
  output logic [31:0]               commit_addr_out,
  output logic [DEPTH_W-1:0]        commit_id_out,
  output logic                      pred_update_out,
  output logic [31:0]               pred_pc_out,
  output logic                      pred_taken_out,
  output logic                      flush_out,
  output logic [31:0]               flush_pc_out,
  output logic                      halt_out
);
  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] FULL = (DEPTH_W+1)'(DEPTH);
  localparam logic [2:0] T_SW = 3'd2, T_JALR = 3'd4, T_BR = 3'd5, T_EXIT = 3'd6;

  logic [DEPTH_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_W:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d, done_q, done_d, ptk_q, ptk_d;
  logic [2:0]         type_q  [DEPTH];
  logic [2:0]         type_d  [DEPTH];
  logic [REG_W-1:0]   dest_q  [DEPTH];
  logic [REG_W-1:0]   dest_d  [DEPTH];
  logic [31:0]        pc_q    [DEPTH];
  logic [31:0]        pc_d    [DEPTH];
  logic [31:0]        paddr_q [DEPTH];
  logic [31:0]        paddr_d [DEPTH];
  logic [31:0]        value_q [DEPTH];
  logic [31:0]        value_d [DEPTH];
  logic [31:0]        addr_q  [DEPTH];
  logic [31:0]        addr_d  [DEPTH];

  logic               commit_valid_q, commit_valid_d, pred_update_q, pred_update_d;
  logic               pred_taken_q, pred_taken_d, flush_q, flush_d, halt_q, halt_d;
  logic [2:0]         commit_type_q, commit_type_d;
  logic [REG_W-1:0]   commit_dest_q, commit_dest_d;
  logic [31:0]        commit_value_q, commit_value_d, commit_addr_q, commit_addr_d;
  logic [DEPTH_W-1:0] commit_id_q, commit_id_d;
  logic [31:0]        pred_pc_q, pred_pc_d, flush_pc_q, flush_pc_d;

  logic               alloc_fire, commit_fire;
  logic [2:0]         h_type;
  logic [31:0]        h_value, h_pc4;

  assign alloc_ready_out = (count_q != FULL) && !flush_q;
  assign alloc_id_out    = tail_q;
  assign alloc_fire      = rdy_in && alloc_valid_in && alloc_ready_out;
  assign h_type          = type_q[head_q];
  assign h_value         = value_q[head_q];
  assign h_pc4           = pc_q[head_q] + 32'd4;
  // Stores (types 0..2) may only leave the head when memory can take them.
  assign commit_fire     = rdy_in && !flush_q && !halt_q && valid_q[head_q] && done_q[head_q]
                           && ((h_type > T_SW) || store_ready_in);

  always_comb begin
    head_d = head_q;  tail_d = tail_q;  count_d = count_q;
    valid_d = valid_q;  done_d = done_q;  ptk_d = ptk_q;
    type_d = type_q;  dest_d = dest_q;  pc_d = pc_q;
    paddr_d = paddr_q;  value_d = value_q;  addr_d = addr_q;
    commit_valid_d = 1'b0;  pred_update_d = 1'b0;  flush_d = 1'b0;
    commit_type_d = commit_type_q;  commit_dest_d = commit_dest_q;
    commit_value_d = commit_value_q;  commit_addr_d = commit_addr_q;
    commit_id_d = commit_id_q;  pred_pc_d = pred_pc_q;  pred_taken_d = pred_taken_q;
    flush_pc_d = flush_pc_q;  halt_d = halt_q;

    if (flush_q) begin
      head_d = '0;  tail_d = '0;  count_d = '0;  valid_d = '0;
    end else if (rdy_in) begin
      // Ascending port order lets the highest-index port win on a shared slot.
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid_in[p] && valid_q[wb_id_in[p*DEPTH_W +: DEPTH_W]]) begin
          done_d[wb_id_in[p*DEPTH_W +: DEPTH_W]]  = 1'b1;
          value_d[wb_id_in[p*DEPTH_W +: DEPTH_W]] = wb_value_in[p*32 +: 32];
          if (type_q[wb_id_in[p*DEPTH_W +: DEPTH_W]] <= T_SW)
            addr_d[wb_id_in[p*DEPTH_W +: DEPTH_W]] = wb_addr_in[p*32 +: 32];
        end
      end
      if (commit_fire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
        commit_valid_d  = 1'b1;
        commit_type_d   = h_type;
        commit_dest_d   = dest_q[head_q];
        commit_id_d     = head_q;
        commit_addr_d   = addr_q[head_q];
        commit_value_d  = (h_type == T_JALR) ? h_pc4 : h_value;
        case (h_type)
          T_JALR: if (h_value != paddr_q[head_q]) begin
            flush_d    = 1'b1;
            flush_pc_d = h_value;
          end
          T_BR: begin
            pred_update_d = 1'b1;
            pred_pc_d     = pc_q[head_q];
            pred_taken_d  = h_value[0];
            if (h_value[0] != ptk_q[head_q]) begin
              flush_d    = 1'b1;
              flush_pc_d = h_value[0] ? paddr_q[head_q] : h_pc4;
            end
          end
          T_EXIT:  halt_d = 1'b1;
          default: ;
        endcase
      end
      // Allocation is applied last so it overrides a same-slot write-back.
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = alloc_done_in;
        ptk_d[tail_q]   = alloc_pred_taken_in;
        type_d[tail_q]  = alloc_type_in;
        dest_d[tail_q]  = alloc_dest_in;
        pc_d[tail_q]    = alloc_pc_in;
        paddr_d[tail_q] = alloc_pred_addr_in;
        value_d[tail_q] = alloc_value_in;
        tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + (DEPTH_W+1)'(alloc_fire) - (DEPTH_W+1)'(commit_fire);
    end
  end

  logic [1:0][DEPTH_W-1:0] q_id;
  logic [1:0]              q_hit;
  logic [1:0][31:0]        q_val;
  assign q_id = {query_id2_in, query_id1_in};

  always_comb begin
    q_hit = '0;
    q_val = '0;
    for (int q = 0; q < 2; q++) begin
      q_hit[q] = valid_q[q_id[q]] && done_q[q_id[q]];
      q_val[q] = value_q[q_id[q]];
`ifdef ROB_WB_BYPASS_EN
      for (int p = 0; p < NUM_WB; p++) begin
        if (!flush_q && wb_valid_in[p] && valid_q[q_id[q]]
            && wb_id_in[p*DEPTH_W +: DEPTH_W] == q_id[q]) begin
          q_hit[q] = 1'b1;
          q_val[q] = wb_value_in[p*32 +: 32];
        end
      end
      if (alloc_fire && alloc_done_in && tail_q == q_id[q]) begin
        q_hit[q] = 1'b1;
        q_val[q] = alloc_value_in;
      end
`endif
    end
  end

  assign query_hit1_out = q_hit[0];
  assign query_hit2_out = q_hit[1];
  assign query_val1_out = q_val[0];
  assign query_val2_out = q_val[1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q <= '0;  tail_q <= '0;  count_q <= '0;
      valid_q <= '0;  done_q <= '0;  ptk_q <= '0;
      type_q <= '{default: '0};  dest_q <= '{default: '0};  pc_q <= '{default: '0};
      paddr_q <= '{default: '0};  value_q <= '{default: '0};  addr_q <= '{default: '0};
      commit_valid_q <= 1'b0;  pred_update_q <= 1'b0;  pred_taken_q <= 1'b0;
      flush_q <= 1'b0;  halt_q <= 1'b0;  commit_type_q <= '0;  commit_dest_q <= '0;
      commit_value_q <= '0;  commit_addr_q <= '0;  commit_id_q <= '0;
      pred_pc_q <= '0;  flush_pc_q <= '0;
    end else begin
      head_q <= head_d;  tail_q <= tail_d;  count_q <= count_d;
      valid_q <= valid_d;  done_q <= done_d;  ptk_q <= ptk_d;
      type_q <= type_d;  dest_q <= dest_d;  pc_q <= pc_d;
      paddr_q <= paddr_d;  value_q <= value_d;  addr_q <= addr_d;
      commit_valid_q <= commit_valid_d;  pred_update_q <= pred_update_d;
      pred_taken_q <= pred_taken_d;  flush_q <= flush_d;  halt_q <= halt_d;
      commit_type_q <= commit_type_d;  commit_dest_q <= commit_dest_d;
      commit_value_q <= commit_value_d;  commit_addr_q <= commit_addr_d;
      commit_id_q <= commit_id_d;  pred_pc_q <= pred_pc_d;  flush_pc_q <= flush_pc_d;
    end
  end

  assign commit_valid_out = commit_valid_q;
  assign commit_type_out  = commit_type_q;
  assign commit_dest_out  = commit_dest_q;
  assign commit_value_out = commit_value_q;
  assign commit_addr_out  = commit_addr_q;
  assign commit_id_out    = commit_id_q;
  assign pred_update_out  = pred_update_q;
  assign pred_pc_out      = pred_pc_q;
  assign pred_taken_out   = pred_taken_q;
  assign flush_out        = flush_q;
  assign flush_pc_out     = flush_pc_q;
  assign halt_out         = halt_q;
endmodule

// File: tb/tb_rob_gen2.sv
// Directed bench for rob_gen2 in its default build (no write-back bypass on queries).
module tb_rob_gen2;
  localparam int DW = 5, NW = 3, RW = 5;
  localparam logic [2:0] T_SW = 3'd2, T_REG = 3'd3, T_JALR = 3'd4, T_BR = 3'd5, T_EXIT = 3'd6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rdy, alloc_valid, alloc_ready, alloc_ptk, alloc_done, store_ready;
  logic [2:0] alloc_type;
  logic [RW-1:0] alloc_dest;
  logic [31:0] alloc_pc, alloc_paddr, alloc_value;
  logic [DW-1:0] alloc_id, q_id1, q_id2;
  logic [NW-1:0] wb_valid;
  logic [NW*DW-1:0] wb_id;
  logic [NW*32-1:0] wb_value, wb_addr;
  logic q_hit1, q_hit2;
  logic [31:0] q_val1, q_val2;
  logic c_valid, p_update, p_taken, flush, halt;
  logic [2:0] c_type;
  logic [RW-1:0] c_dest;
  logic [31:0] c_value, c_addr, p_pc, flush_pc;
  logic [DW-1:0] c_id;

  int n_chk = 0;
  int n_err = 0;

  rob_gen2 #(.DEPTH_W(DW), .NUM_WB(NW), .REG_W(RW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .alloc_valid_in(alloc_valid), .alloc_ready_out(alloc_ready), .alloc_type_in(alloc_type),
    .alloc_dest_in(alloc_dest), .alloc_pc_in(alloc_pc), .alloc_pred_taken_in(alloc_ptk),
    .alloc_pred_addr_in(alloc_paddr), .alloc_done_in(alloc_done), .alloc_value_in(alloc_value),
    .alloc_id_out(alloc_id), .wb_valid_in(wb_valid), .wb_id_in(wb_id),
    .wb_value_in(wb_value), .wb_addr_in(wb_addr),
    .query_id1_in(q_id1), .query_id2_in(q_id2), .query_hit1_out(q_hit1), .query_hit2_out(q_hit2),
    .query_val1_out(q_val1), .query_val2_out(q_val2), .store_ready_in(store_ready),
    .commit_valid_out(c_valid), .commit_type_out(c_type), .commit_dest_out(c_dest),
    .commit_value_out(c_value), .commit_addr_out(c_addr), .commit_id_out(c_id),
    .pred_update_out(p_update), .pred_pc_out(p_pc), .pred_taken_out(p_taken),
    .flush_out(flush), .flush_pc_out(flush_pc), .halt_out(halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [2:0] t, input logic [RW-1:0] d, input logic [31:0] pc,
                          input logic ptk, input logic [31:0] pa, input logic dn, input logic [31:0] v);
    alloc_valid = 1'b1; alloc_type = t; alloc_dest = d; alloc_pc = pc;
    alloc_ptk = ptk; alloc_paddr = pa; alloc_done = dn; alloc_value = v;
    check("alloc_ready_before_alloc", 32'(alloc_ready), 32'd1);
    step();
    alloc_valid = 1'b0; alloc_done = 1'b0;
  endtask

  task automatic wb_set(input int p, input logic [DW-1:0] id, input logic [31:0] v, input logic [31:0] a);
    wb_valid[p] = 1'b1;
    wb_id[p*DW +: DW] = id;
    wb_value[p*32 +: 32] = v;
    wb_addr[p*32 +: 32] = a;
  endtask

  task automatic do_wb(input int p, input logic [DW-1:0] id, input logic [31:0] v, input logic [31:0] a);
    wb_set(p, id, v, a);
    step();
    wb_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic fill32(input string tag);
    for (int i = 0; i < 32; i++) do_alloc(T_REG, RW'(i), 32'(i * 4), 1'b0, 32'd0, 1'b0, 32'd0);
    check({tag, "_full_ready"}, 32'(alloc_ready), 32'd0);
    check({tag, "_full_id"}, 32'(alloc_id), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; store_ready = 1'b1;
    alloc_valid = 1'b0; alloc_type = '0; alloc_dest = '0; alloc_pc = '0;
    alloc_ptk = 1'b0; alloc_paddr = '0; alloc_done = 1'b0; alloc_value = '0;
    wb_valid = '0; wb_id = '0; wb_value = '0; wb_addr = '0;
    q_id1 = '0; q_id2 = '0;
    step();
    do_reset();

    check("rst_alloc_id", 32'(alloc_id), 32'd0);
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_commit_valid", 32'(c_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_query_hit", 32'(q_hit1), 32'd0);

    // Fill all 32 slots, then free one by completing the head.
    fill32("fill");
    do_wb(0, 5'd0, 32'h11, 32'd0);
    check("fill_no_commit_yet", 32'(c_valid), 32'd0);
    check("fill_still_full", 32'(alloc_ready), 32'd0);
    step();
    check("fill_commit_valid", 32'(c_valid), 32'd1);
    check("fill_commit_id", 32'(c_id), 32'd0);
    check("fill_commit_value", c_value, 32'h11);
    check("fill_commit_type", 32'(c_type), 32'(T_REG));
    check("fill_ready_after", 32'(alloc_ready), 32'd1);
    step();
    check("fill_pulse_end", 32'(c_valid), 32'd0);

    // Out-of-order write-back, in-order commit.
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(T_REG, RW'(i + 1), 32'(i * 4), 1'b0, 32'd0, 1'b0, 32'd0);
    do_wb(2, 5'd2, 32'd3, 32'd0);
    check("ooo_hold_1", 32'(c_valid), 32'd0);
    do_wb(1, 5'd1, 32'd2, 32'd0);
    check("ooo_hold_2", 32'(c_valid), 32'd0);
    do_wb(0, 5'd0, 32'd1, 32'd0);
    check("ooo_hold_3", 32'(c_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ooo_commit_valid", 32'(c_valid), 32'd1);
      check("ooo_commit_id", 32'(c_id), 32'(i));
      check("ooo_commit_value", c_value, 32'(i + 1));
      check("ooo_commit_dest", 32'(c_dest), 32'(i + 1));
    end
    step();
    check("ooo_drained", 32'(c_valid), 32'd0);

    // Multi-port write-back to one slot plus queries.
    do_alloc(T_REG, 5'd9, 32'h50, 1'b0, 32'd0, 1'b0, 32'd0);
    q_id1 = 5'd3; q_id2 = 5'd2;
    #1;
    check("query_not_done", 32'(q_hit1), 32'd0);
    check("query_committed_slot", 32'(q_hit2), 32'd0);
    wb_set(0, 5'd3, 32'hA, 32'd0);
    wb_set(2, 5'd3, 32'hC, 32'd0);
    #1;
    check("query_no_bypass", 32'(q_hit1), 32'd0);
    step();
    wb_valid = '0;
    check("query_hit_after_wb", 32'(q_hit1), 32'd1);
    check("query_val_high_port", q_val1, 32'hC);
    step();
    check("multi_wb_commit_value", c_value, 32'hC);
    check("query_hit_after_commit", 32'(q_hit1), 32'd0);

    // Branch mispredict flushes younger entries.
    do_reset();
    do_alloc(T_BR, 5'd0, 32'h100, 1'b0, 32'h140, 1'b0, 32'd0);
    do_alloc(T_REG, 5'd1, 32'h104, 1'b0, 32'd0, 1'b1, 32'h55);
    do_alloc(T_REG, 5'd2, 32'h108, 1'b0, 32'd0, 1'b0, 32'd0);
    do_wb(0, 5'd0, 32'd1, 32'd0);
    check("br_no_commit_yet", 32'(c_valid), 32'd0);
    step();
    check("br_commit_valid", 32'(c_valid), 32'd1);
    check("br_pred_update", 32'(p_update), 32'd1);
    check("br_pred_pc", p_pc, 32'h100);
    check("br_pred_taken", 32'(p_taken), 32'd1);
    check("br_flush", 32'(flush), 32'd1);
    check("br_flush_pc", flush_pc, 32'h140);
    check("br_ready_during_flush", 32'(alloc_ready), 32'd0);
    q_id1 = 5'd1;
    step();
    check("br_flush_end", 32'(flush), 32'd0);
    check("br_no_young_commit", 32'(c_valid), 32'd0);
    check("br_pred_update_end", 32'(p_update), 32'd0);
    check("br_tail_zero", 32'(alloc_id), 32'd0);
    check("br_young_gone", 32'(q_hit1), 32'd0);
    step();
    check("br_still_no_commit", 32'(c_valid), 32'd0);
    fill32("br_count0");

    // JALR: correct then mispredicted target.
    do_reset();
    do_alloc(T_JALR, 5'd1, 32'h200, 1'b0, 32'h300, 1'b0, 32'd0);
    do_wb(0, 5'd0, 32'h300, 32'd0);
    step();
    check("jalr_ok_valid", 32'(c_valid), 32'd1);
    check("jalr_ok_value", c_value, 32'h204);
    check("jalr_ok_flush", 32'(flush), 32'd0);
    check("jalr_ok_no_pred_update", 32'(p_update), 32'd0);
    do_alloc(T_JALR, 5'd1, 32'h200, 1'b0, 32'h300, 1'b0, 32'd0);
    do_wb(0, 5'd1, 32'h304, 32'd0);
    step();
    check("jalr_bad_value", c_value, 32'h204);
    check("jalr_bad_flush", 32'(flush), 32'd1);
    check("jalr_bad_flush_pc", flush_pc, 32'h304);
    step();
    check("jalr_flush_end", 32'(flush), 32'd0);
    check("jalr_tail_zero", 32'(alloc_id), 32'd0);

    // Store held at head until memory is ready.
    do_reset();
    store_ready = 1'b0;
    do_alloc(T_SW, 5'd0, 32'h400, 1'b0, 32'd0, 1'b0, 32'd0);
    do_wb(1, 5'd0, 32'hDEAD, 32'h1000);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_stall", 32'(c_valid), 32'd0);
    end
    store_ready = 1'b1;
    step();
    check("st_commit_valid", 32'(c_valid), 32'd1);
    check("st_commit_type", 32'(c_type), 32'(T_SW));
    check("st_commit_addr", c_addr, 32'h1000);
    check("st_commit_value", c_value, 32'hDEAD);

    // Asynchronous reset with live entries.
    do_reset();
    do_alloc(T_REG, 5'd7, 32'h0, 1'b0, 32'd0, 1'b1, 32'h77);
    do_alloc(T_REG, 5'd1, 32'h4, 1'b0, 32'd0, 1'b0, 32'd0);
    do_alloc(T_REG, 5'd2, 32'h8, 1'b0, 32'd0, 1'b1, 32'h99);
    for (int i = 3; i < 6; i++) do_alloc(T_REG, RW'(i), 32'(i * 4), 1'b0, 32'd0, 1'b0, 32'd0);
    q_id1 = 5'd2;
    #1;
    check("ar_pre_id", 32'(alloc_id), 32'd6);
    check("ar_pre_hit", 32'(q_hit1), 32'd1);
    check("ar_pre_val", q_val1, 32'h99);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_commit_value_zero", c_value, 32'd0);
    check("ar_commit_dest_zero", 32'(c_dest), 32'd0);
    check("ar_alloc_id_zero", 32'(alloc_id), 32'd0);
    check("ar_query_hit_zero", 32'(q_hit1), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("ar_post_id", 32'(alloc_id), 32'd0);
    check("ar_post_hit", 32'(q_hit1), 32'd0);
    check("ar_post_commit", 32'(c_valid), 32'd0);

    // EXIT makes halt sticky and stops later commits.
    do_alloc(T_EXIT, 5'd0, 32'h10, 1'b0, 32'd0, 1'b1, 32'd0);
    check("exit_halt_pre", 32'(halt), 32'd0);
    do_alloc(T_REG, 5'd3, 32'h14, 1'b0, 32'd0, 1'b1, 32'h5);
    check("exit_commit_valid", 32'(c_valid), 32'd1);
    check("exit_commit_type", 32'(c_type), 32'(T_EXIT));
    check("exit_halt", 32'(halt), 32'd1);
    step();
    check("exit_no_more_commit", 32'(c_valid), 32'd0);
    step();
    check("exit_halt_sticky", 32'(halt), 32'd1);

    // Global stall ignores allocation.
    rdy = 1'b0;
    do_alloc(T_REG, 5'd4, 32'h18, 1'b0, 32'd0, 1'b0, 32'd0);
    check("stall_tail_held", 32'(alloc_id), 32'd2);
    rdy = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
